// File: rtl/cpu_pkg.sv
// Shared fetch-stage types: handshake FSM states, NOP encoding, default PC step.
// Pure declarations; no timing or backpressure of its own.
package cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC    = 32'd4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory req/ready/rvalid channel; master is the fetch stage.
// One request in flight; ready backpressures req, rvalid is a single-cycle pulse.
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ready_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_ready_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_ready_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/fetch_pc_reg.sv
// Program counter with redirect/increment next-PC mux; updates on the edge after select.
// No backpressure: holds unless told to advance or redirect (redirect wins).
module fetch_pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = cpu_pkg::PC_INC
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  input  logic        i_advance,
  output logic [31:0] o_pc
);
  import cpu_pkg::*;

  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;

  always_comb begin
    w_pc_nxt = r_pc;
    if (i_redirect) begin
      w_pc_nxt = word_align(i_redirect_pc);
    end else if (i_advance) begin
      w_pc_nxt = r_pc + PC_INC;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: single-outstanding imem requests into a registered {pc,instr,valid} buffer.
// Best case one instruction per 2 cycles; stall holds the buffer and blocks new requests.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = cpu_pkg::PC_INC
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master imem,
  input  logic         stall_i,
  input  logic         redirect_i,
  input  logic [31:0]  redirect_pc_i,
  output logic [31:0]  pc_o,
  output logic [31:0]  instr_o,
  output logic         valid_o,
  output logic         fetch_busy_o
);
  import cpu_pkg::*;

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  logic [31:0]  w_pc_q;
  logic [31:0]  r_inflight_pc;
  logic [31:0]  r_pc_o;
  logic [31:0]  r_instr_o;
  logic         r_valid_o;
  logic         w_req;
  logic         w_accept;
  logic         w_load;

  fetch_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .i_redirect    (redirect_i),
    .i_redirect_pc (redirect_pc_i),
    .i_advance     (w_accept),
    .o_pc          (w_pc_q)
  );

  // A request is only issued when the buffer will be free by the time data returns.
  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_REQ: begin
        w_req = ~redirect_i & (~r_valid_o | ~stall_i);
        if (w_req && imem.imem_ready_i) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (redirect_i) begin
          w_state_nxt = imem.imem_rvalid_i ? S_REQ : S_DRAIN;
        end else if (imem.imem_rvalid_i) begin
          w_load      = 1'b1;
          w_state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem.imem_rvalid_i) w_state_nxt = S_REQ;
      end
      default: w_state_nxt = S_REQ;
    endcase
  end

  assign w_accept = w_req & imem.imem_ready_i;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_inflight_pc <= RESET_PC;
    end else if (w_accept) begin
      r_inflight_pc <= w_pc_q;
    end
  end

  // pc_o deliberately keeps its last value when the buffer empties.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_pc_o    <= RESET_PC;
      r_instr_o <= NOP_INSTR;
      r_valid_o <= 1'b0;
    end else if (redirect_i) begin
      r_instr_o <= NOP_INSTR;
      r_valid_o <= 1'b0;
    end else if (w_load) begin
      r_pc_o    <= r_inflight_pc;
      r_instr_o <= imem.imem_rdata_i;
      r_valid_o <= 1'b1;
    end else if (r_valid_o && !stall_i) begin
      r_instr_o <= NOP_INSTR;
      r_valid_o <= 1'b0;
    end
  end

  assign imem.imem_req_o  = w_req & rst_i;
  assign imem.imem_addr_o = w_pc_q;
  assign pc_o             = r_pc_o;
  assign instr_o          = r_instr_o;
  assign valid_o          = r_valid_o;
  assign fetch_busy_o     = ~r_valid_o;

endmodule
